// File: rtl/dff_pipe_bank.sv
// WIDTH x DEPTH pipeline register bank with valid/ready flow control, bubble collapse,
// flush, full-bank scan chain and an inverted output copy.
module dff_pipe_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] RST_VALUE = '1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             Q_VALID,
    input  logic             Q_READY,
    input  logic             FLUSH,
    input  logic             SE,
    input  logic             SI,
    output logic             SO
);

    localparam int CHAIN = WIDTH * DEPTH;

    if (DEPTH < 1) begin : g_bad_depth
        $error("dff_pipe_bank: DEPTH must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("dff_pipe_bank: WIDTH must be at least 1");
    end

    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0][WIDTH-1:0] up_data;
    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0]            up_valid;
    logic [DEPTH-1:0]            adv;
    logic [CHAIN-1:0]            scan_next;

    // A stage may advance if it is empty or the stage after it is advancing.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = !valid[DEPTH-1] || Q_READY;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = !valid[i] || adv[i+1];
        end
    end

    always_comb begin
        up_data     = '0;
        up_valid    = '0;
        up_data[0]  = D;
        up_valid[0] = D_VALID;
        for (int i = 1; i < DEPTH; i++) begin
            up_data[i]  = data[i-1];
            up_valid[i] = valid[i-1];
        end
    end

    // The flattened bank shifts toward the last stage's MSB, SI entering at stage 0 bit 0.
    assign scan_next = CHAIN'({data, SI});

    always_ff @(posedge CLK) begin
        if (RST) begin
            data  <= {DEPTH{RST_VALUE}};
            valid <= '0;
        end else if (SE) begin
            data <= scan_next;
        end else if (FLUSH) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    valid[i] <= up_valid[i];
                    if (up_valid[i]) begin
                        data[i] <= up_data[i];
                    end
                end
            end
        end
    end

    assign D_READY = adv[0] && !FLUSH && !SE && !RST;
    assign Q       = data[DEPTH-1];
    assign QN      = ~data[DEPTH-1];
    assign Q_VALID = valid[DEPTH-1] && !SE;
    assign SO      = data[DEPTH-1][WIDTH-1];

endmodule

// File: tb/tb_dff_pipe_bank.sv
// Randomised and directed bench for dff_pipe_bank, checked every cycle against a
// word-queue reference model of the bank.
module tb_dff_pipe_bank;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam logic [WIDTH-1:0] RST_VALUE = 8'hFF;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] D;
    logic             D_VALID;
    logic             D_READY;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] QN;
    logic             Q_VALID;
    logic             Q_READY;
    logic             FLUSH;
    logic             SE;
    logic             SI;
    logic             SO;

    int checks = 0;
    int errors = 0;

    // Model: contents of each stage register, plus the in-flight words as a queue of
    // stage positions, oldest first.
    logic [WIDTH-1:0] stageData [DEPTH];
    int               wordPos[$];
    bit               modelKnown = 0;

    dff_pipe_bank #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RST_VALUE(RST_VALUE)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .D(D),
        .D_VALID(D_VALID),
        .D_READY(D_READY),
        .Q(Q),
        .QN(QN),
        .Q_VALID(Q_VALID),
        .Q_READY(Q_READY),
        .FLUSH(FLUSH),
        .SE(SE),
        .SI(SI),
        .SO(SO)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // The bank takes a word unless it is full and nothing is leaving.
    function automatic bit expReady();
        return !RST && !SE && !FLUSH && ((wordPos.size() < DEPTH) || Q_READY);
    endfunction

    function automatic bit expQValid();
        return !SE && (wordPos.size() > 0) && (wordPos[0] == DEPTH - 1);
    endfunction

    task automatic compareAll();
        logic [WIDTH-1:0] expQ;
        logic [WIDTH-1:0] expQn;
        checkOutput("d_ready", D_READY, expReady());
        if (modelKnown) begin
            expQ  = stageData[DEPTH-1];
            expQn = ~expQ;
            checkOutput("q", Q, expQ);
            checkOutput("qn", QN, expQn);
            checkOutput("q_valid", Q_VALID, expQValid());
            checkOutput("so", SO, expQ[WIDTH-1]);
        end
    endtask

    task automatic modelEdge();
        logic [WIDTH*DEPTH-1:0] bits;
        bit accept;
        if (RST) begin
            wordPos.delete();
            for (int s = 0; s < DEPTH; s++) stageData[s] = RST_VALUE;
            modelKnown = 1;
        end else if (SE) begin
            for (int s = 0; s < DEPTH; s++)
                for (int b = 0; b < WIDTH; b++) bits[s*WIDTH+b] = stageData[s][b];
            bits = {bits[WIDTH*DEPTH-2:0], SI};
            for (int s = 0; s < DEPTH; s++)
                for (int b = 0; b < WIDTH; b++) stageData[s][b] = bits[s*WIDTH+b];
        end else if (FLUSH) begin
            wordPos.delete();
        end else begin
            accept = D_VALID && expReady();
            if (expQValid() && Q_READY) void'(wordPos.pop_front());
            for (int k = 0; k < wordPos.size(); k++) begin
                if (wordPos[k] < DEPTH - 1 && (k == 0 || wordPos[k-1] > wordPos[k] + 1)) begin
                    stageData[wordPos[k]+1] = stageData[wordPos[k]];
                    wordPos[k]++;
                end
            end
            if (accept) begin
                stageData[0] = D;
                wordPos.push_back(0);
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic se, input logic fl,
                                 input logic dv, input logic [WIDTH-1:0] d,
                                 input logic qr, input logic si);
        RST = rst; SE = se; FLUSH = fl; D_VALID = dv; D = d; Q_READY = qr; SI = si;
        #1;
        compareAll();
        @(posedge CLK);
        modelEdge();
        @(negedge CLK);
    endtask

    initial begin
        logic [15:0] pattern;

        // Reset held two cycles with a valid input being offered.
        applyStimulus(1, 0, 0, 1, 8'h00, 0, 0);
        applyStimulus(1, 0, 0, 1, 8'h00, 0, 0);
        RST = 0; D_VALID = 0; SE = 0; FLUSH = 0; Q_READY = 0;
        #1;
        checkOutput("rst_q", Q, 8'hFF);
        checkOutput("rst_qn", QN, 8'h00);
        checkOutput("rst_qvalid", Q_VALID, 1'b0);
        checkOutput("rst_so", SO, 1'b1);
        checkOutput("rst_dready", D_READY, 1'b1);

        // Streaming with downstream always ready.
        applyStimulus(0, 0, 0, 1, 8'h11, 1, 0);
        applyStimulus(0, 0, 0, 1, 8'h22, 1, 0);
        checkOutput("stream_first_q", Q, 8'h11);
        checkOutput("stream_first_qn", QN, 8'hEE);
        applyStimulus(0, 0, 0, 1, 8'h33, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 8'h00, 1, 0);

        // Backpressure with a bubble, then drain.
        applyStimulus(0, 0, 0, 1, 8'hA1, 0, 0);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'hA2, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'hA3, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'hA3, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'hA3, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 8'h00, 1, 0);

        // Flush with two words in flight and a competing input.
        applyStimulus(0, 0, 0, 1, 8'h5A, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'h5B, 0, 0);
        applyStimulus(0, 0, 1, 1, 8'h55, 0, 0);
        checkOutput("flush_qvalid", Q_VALID, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 8'h00, 1, 0);

        // Scan over a full bank; the top bit goes in first so stage 1 ends as C3.
        applyStimulus(0, 0, 0, 1, 8'h01, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'h02, 0, 0);
        pattern = 16'hC3A5;
        for (int k = 0; k < 16; k++) applyStimulus(0, 1, 0, 0, 8'h00, 0, pattern[15-k]);
        SE = 0; Q_READY = 0; D_VALID = 0;
        #1;
        checkOutput("scan_q", Q, 8'hC3);
        checkOutput("scan_qvalid", Q_VALID, 1'b1);
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 0);
        checkOutput("scan_second_q", Q, 8'hA5);
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 0);

        // Priority: reset beats scan and flush; then scan ignores flush.
        applyStimulus(0, 0, 0, 1, 8'h77, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'h78, 0, 0);
        applyStimulus(1, 1, 1, 1, 8'h00, 0, 1);
        RST = 0; SE = 0; FLUSH = 0; D_VALID = 0;
        #1;
        checkOutput("prio_q", Q, 8'hFF);
        checkOutput("prio_qvalid", Q_VALID, 1'b0);
        applyStimulus(0, 0, 0, 1, 8'h3C, 1, 0);
        applyStimulus(0, 0, 0, 1, 8'h3D, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 8'h00, 0, i[0]);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 8'h00, 1, 0);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 59) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 11) == 0,
                          $urandom_range(0, 1) == 1,
                          WIDTH'($urandom),
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
